// File: rtl/interrupt_request_unit_pkg.sv
// Shared definitions for the interrupt request unit.
//   irsState_t          : FSM state codes (2-bit encoding)
//   TRUE / FALSE        : single-bit constants
//   EV_INT_0 / EV_INT_1 : exception vectors taken for interrupt IDs 0 and 1
//   irqIdToVector()     : maps the IID_Sync value to its exception vector
package interrupt_request_unit_pkg;

  typedef enum logic [1:0] {
    IRS_IDLE = 2'd0,
    IRS_REQ  = 2'd1,
    IRS_HOLD = 2'd2
  } irsState_t;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [4:0] EV_INT_0 = 5'd16;
  localparam logic [4:0] EV_INT_1 = 5'd17;

  function automatic logic [4:0] irqIdToVector(input logic iid);
    return iid ? EV_INT_1 : EV_INT_0;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Single-line synchroniser plus rising-edge detector.
// Ports:
//   Clock   in  core clock
//   Reset   in  synchronous, active-high
//   AsyncIn in  asynchronous interrupt pin
//   Rise    out one-cycle pulse when the synchronised line goes 0 -> 1
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic AsyncIn,
  output logic Rise
);

  if (SYNC_STAGES < 2) begin : gBadSyncStages
    $error("irq_sync_edge: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] syncChain;
  logic                   syncPrev;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      syncChain <= '0;
      syncPrev  <= 1'b0;
    end else begin
      syncChain <= {syncChain[SYNC_STAGES-2:0], AsyncIn};
      syncPrev  <= syncChain[SYNC_STAGES-1];
    end
  end

  assign Rise = syncChain[SYNC_STAGES-1] & ~syncPrev;

endmodule

// File: rtl/interrupt_request_unit.sv
// Interrupt request unit: synchronises two external interrupt pins, latches
// rising edges as pending requests, arbitrates (line 1 wins) and holds a
// registered request/ID towards the exception controller until acknowledged.
// Ports:
//   Clock      in   core clock
//   Reset      in   synchronous, active-high
//   IRQ_Ext    in   [1:0] asynchronous interrupt pins
//   IntEnable  in   [1:0] per-line enable
//   IntAck     in   one-cycle acknowledge while requesting
//   OvrClear   in   clears IntOverrun
//   IRQ_Int    out  registered interrupt request
//   IID_Sync   out  registered ID of the requesting line
//   IntPending out  [1:0] pending flags
//   IntOverrun out  [1:0] sticky overrun flags
//
// state    | meaning
// IRS_IDLE | no request; waits for an enabled pending line
// IRS_REQ  | requesting with a frozen ID until ack or enable withdrawal
// IRS_HOLD | post-ack gap of HOLDOFF_CYCLES before the next request
module interrupt_request_unit
  import interrupt_request_unit_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLDOFF_CYCLES = 3
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] IRQ_Ext,
  input  logic [1:0] IntEnable,
  input  logic       IntAck,
  input  logic       OvrClear,
  output logic       IRQ_Int,
  output logic       IID_Sync,
  output logic [1:0] IntPending,
  output logic [1:0] IntOverrun
);

  if (HOLDOFF_CYCLES < 1 || HOLDOFF_CYCLES > 15) begin : gBadHoldoff
    $error("interrupt_request_unit: HOLDOFF_CYCLES must be within 1..15");
  end

  localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF_CYCLES - 1);

  irsState_t  state, stateNext;
  logic       lockedId, lockedIdNext;
  logic [3:0] holdCnt, holdCntNext;
  logic [1:0] rise;
  logic [1:0] ackClear;
  logic [1:0] eligible;

  for (genvar n = 0; n < 2; n++) begin : gLine
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uSyncEdge (
      .Clock  (Clock),
      .Reset  (Reset),
      .AsyncIn(IRQ_Ext[n]),
      .Rise   (rise[n])
    );
  end

  // Only the line actually being acknowledged is cleared; a fresh edge on
  // that same line in the ack cycle re-sets it below.
  assign ackClear = (IntAck && state == IRS_REQ) ? (2'b01 << lockedId) : 2'b00;
  assign eligible = IntPending & IntEnable;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      IntPending <= 2'b00;
      IntOverrun <= 2'b00;
    end else begin
      IntPending <= (IntPending & ~ackClear) | rise;
      IntOverrun <= (OvrClear ? 2'b00 : IntOverrun) | (rise & IntPending & ~ackClear);
    end
  end

  always_comb begin
    stateNext    = state;
    lockedIdNext = lockedId;
    holdCntNext  = holdCnt;
    case (state)
      IRS_IDLE: begin
        if (|eligible) begin
          stateNext    = IRS_REQ;
          lockedIdNext = eligible[1];
        end
      end
      IRS_REQ: begin
        // Ack wins over a same-cycle enable drop: the interrupt was taken.
        if (IntAck) begin
          stateNext   = IRS_HOLD;
          holdCntNext = HOLD_LOAD;
        end else if (!IntEnable[lockedId]) begin
          stateNext = IRS_IDLE;
        end
      end
      IRS_HOLD: begin
        if (holdCnt == 4'd0) begin
          stateNext = IRS_IDLE;
        end else begin
          holdCntNext = holdCnt - 4'd1;
        end
      end
      default: stateNext = IRS_IDLE;
    endcase
  end

  // IRQ_Int is decoded from the next state so it is a clean flop output
  // that tracks REQ exactly.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IRS_IDLE;
      lockedId <= 1'b0;
      holdCnt  <= 4'd0;
      IRQ_Int  <= FALSE;
    end else begin
      state    <= stateNext;
      lockedId <= lockedIdNext;
      holdCnt  <= holdCntNext;
      IRQ_Int  <= (stateNext == IRS_REQ) ? TRUE : FALSE;
    end
  end

  assign IID_Sync = lockedId;

endmodule

// File: tb/tb_interrupt_request_unit.sv
module tb_interrupt_request_unit;

  localparam int SYNC = 2;
  localparam int HOLD = 3;

  typedef struct packed {
    logic       irq;
    logic       iid;
    logic [1:0] pend;
    logic [1:0] ovr;
  } outRec_t;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [1:0] IRQ_Ext;
  logic [1:0] IntEnable;
  logic       IntAck;
  logic       OvrClear;
  logic       IRQ_Int;
  logic       IID_Sync;
  logic [1:0] IntPending;
  logic [1:0] IntOverrun;

  interrupt_request_unit #(.SYNC_STAGES(SYNC), .HOLDOFF_CYCLES(HOLD)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .IRQ_Ext   (IRQ_Ext),
    .IntEnable (IntEnable),
    .IntAck    (IntAck),
    .OvrClear  (OvrClear),
    .IRQ_Int   (IRQ_Int),
    .IID_Sync  (IID_Sync),
    .IntPending(IntPending),
    .IntOverrun(IntOverrun)
  );

  always #5 Clock = ~Clock;

  int assertCount = 0;
  int failCount   = 0;
  outRec_t expQ[$];

  // ---------------- reference model ----------------
  // Pins are kept as a per-edge history; an edge reaches the pending flags
  // SYNC edges after it is sampled. Holdoff is tracked as a timestamp.
  logic [1:0] pinHist[$];
  int         edgeIdx   = 0;
  int         lastReset = 0;
  int         holdEnd   = -1000;
  logic       mReq = 1'b0;
  logic       mId  = 1'b0;
  logic [1:0] mPend = 2'b00;
  logic [1:0] mOvr  = 2'b00;

  logic       curRst = 1'b1;
  logic [1:0] curExt = 2'b00;
  logic [1:0] curEn  = 2'b00;
  logic       curAck = 1'b0;
  logic       curOc  = 1'b0;
  bit         started = 1'b0;

  function automatic logic [1:0] pinAt(input int j);
    if (j < 0 || j <= lastReset) return 2'b00;
    return pinHist[j];
  endfunction

  task automatic modelEdge();
    logic [1:0] rise, clr, elig;
    logic ackHit;
    int t;
    t = edgeIdx;
    pinHist.push_back(curExt);
    if (curRst) begin
      lastReset = t;
      mPend = 2'b00; mOvr = 2'b00; mReq = 1'b0; mId = 1'b0; holdEnd = -1000;
    end else begin
      rise   = pinAt(t - SYNC) & ~pinAt(t - SYNC - 1);
      ackHit = curAck && mReq;
      clr    = 2'b00;
      if (ackHit) clr[mId] = 1'b1;
      mOvr = (curOc ? 2'b00 : mOvr) | (rise & mPend & ~clr);
      elig = mPend & curEn;
      if (mReq) begin
        if (ackHit) begin
          mReq = 1'b0;
          holdEnd = t + HOLD;
        end else if (!curEn[mId]) begin
          mReq = 1'b0;
        end
      end else if (t > holdEnd && elig != 2'b00) begin
        mReq = 1'b1;
        mId  = elig[1];
      end
      mPend = (mPend & ~clr) | rise;
    end
    expQ.push_back('{irq: mReq, iid: mId, pend: mPend, ovr: mOvr});
    edgeIdx++;
  endtask

  // ---------------- driver ----------------
  task automatic step();
    if (started) begin
      @(posedge Clock);
      #1;
    end
    started   = 1'b1;
    Reset     = curRst;
    IRQ_Ext   = curExt;
    IntEnable = curEn;
    IntAck    = curAck;
    OvrClear  = curOc;
    modelEdge();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse(input logic [1:0] lines, input int len);
    curExt = lines;
    steps(len);
    curExt = 2'b00;
    step();
  endtask

  task automatic waitReq();
    int k;
    k = 0;
    while (!mReq && k < 30) begin
      step();
      k++;
    end
    if (!mReq) begin
      failCount++;
      $display("FAIL waitReq: no request within 30 cycles, required one");
    end
  endtask

  task automatic ackReq();
    waitReq();
    curAck = 1'b1;
    step();
    curAck = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    outRec_t e;
    forever begin
      @(posedge Clock);
      if (expQ.size() > 0) begin
        @(negedge Clock);
        e = expQ.pop_front();
        assertCount++;
        if ({IRQ_Int, IID_Sync, IntPending, IntOverrun} !== e) begin
          failCount++;
          $display("FAIL outputs @%0t: got irq=%b iid=%b pend=%b ovr=%b, expected irq=%b iid=%b pend=%b ovr=%b",
                   $time, IRQ_Int, IID_Sync, IntPending, IntOverrun, e.irq, e.iid, e.pend, e.ovr);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    curRst = 1'b1;
    steps(2);
    curRst = 1'b0;

    // single line 0 request, ack, holdoff
    curEn = 2'b11;
    pulse(2'b01, 5);
    ackReq();
    steps(8);

    // simultaneous edges: line 1 first, then line 0 after holdoff
    pulse(2'b11, 3);
    ackReq();
    ackReq();
    steps(6);

    // ID frozen while line 1 arrives during a line 0 request
    pulse(2'b01, 3);
    waitReq();
    pulse(2'b10, 3);
    steps(4);
    ackReq();
    ackReq();
    steps(6);

    // overrun on line 0, clear, and clear colliding with a new overrun
    curEn = 2'b00;
    pulse(2'b01, 2);
    steps(2);
    pulse(2'b01, 2);
    steps(4);
    curOc = 1'b1;
    step();
    curOc = 1'b0;
    steps(2);
    curOc = 1'b1;
    pulse(2'b01, 2);
    steps(4);
    curOc = 1'b0;
    steps(2);
    curOc = 1'b1;
    step();
    curOc = 1'b0;
    curEn = 2'b11;
    ackReq();
    steps(6);

    // masked line 1, enable it, then withdraw the request
    curEn = 2'b00;
    pulse(2'b10, 3);
    steps(6);
    curEn = 2'b10;
    steps(3);
    curEn = 2'b00;
    steps(3);
    curEn = 2'b11;
    ackReq();
    steps(6);

    // reset mid-request, ack while idle
    pulse(2'b01, 3);
    waitReq();
    curRst = 1'b1;
    step();
    curRst = 1'b0;
    curAck = 1'b1;
    steps(2);
    curAck = 1'b0;
    steps(3);

    // edge landing in the same cycle as its own ack
    pulse(2'b01, 1);
    waitReq();
    curExt = 2'b01;
    steps(SYNC);
    curAck = 1'b1;
    step();
    curAck = 1'b0;
    curExt = 2'b00;
    steps(3);
    ackReq();
    steps(6);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) curExt[0] = ~curExt[0];
      if ($urandom_range(0, 6) == 0) curExt[1] = ~curExt[1];
      if ($urandom_range(0, 15) == 0) curEn = 2'($urandom_range(0, 3));
      curAck = mReq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      curOc  = ($urandom_range(0, 7) == 0);
      curRst = ($urandom_range(0, 299) == 0);
      step();
    end
    curRst = 1'b0; curAck = 1'b0; curOc = 1'b0;
    steps(2);

    k = 0;
    while (expQ.size() > 0 && k < 10) begin
      @(negedge Clock);
      k++;
    end
    #2;
    if (expQ.size() > 0) begin
      failCount++;
      $display("FAIL drain: %0d expected records left, required 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
